medidor_frecuencia: RTL

Frequency meter, the inverse of the divider path. It counts rising edges of an asynchronous square wave over a fixed gate window and reports the result as an 8-bit frequency number. This is the same encoding the divider consumes, which lets the board measure its own divided clock or an external signal and show the result on the display. It sits beside the divider on the 100 MHz system clock.

---
 rtl/medidor_frecuencia.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/medidor_frecuencia.sv
// -----------------------------------------------------------------------------
// medidor_frecuencia
//
// Frequency meter. Counts rising edges of an asynchronous square wave over a
// fixed gate window of GATE_CYCLES clk cycles and reports the count as an
// 8-bit frequency number (saturated at 255). With the default 1 ms window on
// a 100 MHz clock the result reads directly in kHz, which is the same encoding
// the clock divider consumes.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (>= 4)
//   GW           gate counter width, 2**GW > GATE_CYCLES
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   en          continuous-measure enable (level)
//   sig_in      signal to measure, asynchronous to clk
//   frecnum     last measured edge count, saturated at 255
//   frec_valid  one-cycle strobe when frecnum/overflow update
//   overflow    last window counted more than 255 edges
//   busy        high while a gate window is open
// -----------------------------------------------------------------------------
module medidor_frecuencia #(
  parameter int GATE_CYCLES = 100000,
  parameter int GW          = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sig_in,
  output logic [7:0] frecnum,
  output logic       frec_valid,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    UPDATE
  } state_t;

  state_t state, next_state;

  logic          s1, s2, s3;
  logic          e;
  logic [GW-1:0] gate_cnt;
  logic [15:0]   edge_cnt;
  logic          last_gate;
  logic [7:0]    sat_num;
  logic          sat_ovf;
  logic [7:0]    frecnum_q;
  logic          overflow_q;

  // Two-flop synchronizer for the asynchronous input followed by one more
  // delay stage, so a rising edge shows up as a single-cycle pulse on e.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign e         = s2 & ~s3;
  assign last_gate = (gate_cnt == GW'(GATE_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Dropping en inside a window abandons it without an
  // update; UPDATE chains straight into a new window while en stays high.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = en ? GATE : IDLE;
      GATE: begin
        if (!en) begin
          next_state = IDLE;
        end else if (last_gate) begin
          next_state = UPDATE;
        end else begin
          next_state = GATE;
        end
      end
      UPDATE:  next_state = en ? GATE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gate and edge counters. Both are cleared whenever a new window is about
  // to open; the edge counter sticks at 0xFFFF instead of wrapping so a very
  // fast input can never alias to a small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        IDLE, UPDATE: begin
          if (en) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + GW'(1);
          if (e && (edge_cnt != 16'hFFFF)) begin
            edge_cnt <= edge_cnt + 16'd1;
          end
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

  // Saturated view of the finished window's edge count.
  always_comb begin
    sat_ovf = (edge_cnt > 16'd255);
    sat_num = sat_ovf ? 8'hFF : edge_cnt[7:0];
  end

  // Result registers, loaded at the end of the UPDATE cycle and held until
  // the next completed window.
  always_ff @(posedge clk) begin
    if (reset) begin
      frecnum_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else if (state == UPDATE) begin
      frecnum_q  <= sat_num;
      overflow_q <= sat_ovf;
    end
  end

  // Output logic. During the UPDATE cycle the new result is forwarded so
  // that a consumer capturing on frec_valid sees the fresh value rather than
  // the previous window's.
  always_comb begin
    busy       = (state == GATE);
    frec_valid = (state == UPDATE);
    frecnum    = frec_valid ? sat_num : frecnum_q;
    overflow   = frec_valid ? sat_ovf : overflow_q;
  end

endmodule
